// File: rtl/vga_fetch_pkg.sv
// Shared types and helpers for the VGA pixel fetch block.
package vga_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Number of bits needed to represent 'value' (minimum 1).
    function automatic int clogb2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 32'sd0) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        if (r == 32'sd0) begin
            r = 32'sd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word fall-through FIFO: the head entry is always visible on pop_data.
module fwft_fifo
    import vga_fetch_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 4,
    localparam int PW         = clogb2(FIFO_DEPTH - 1),
    localparam int CW         = clogb2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CW-1:0]     count,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == {CW{1'b0}});
    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_wr_en  = push && (!w_full || pop);
    assign w_rd_en  = pop && !w_empty;

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign empty    = w_empty;

    // Storage array; contents need no reset because validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1'b1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    fwft_fifo_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: rtl/fwft_fifo_chk.sv
// Property checker for the first-word fall-through pixel FIFO.
module fwft_fifo_chk (
    input logic clk,
    input logic rst,
    input logic flush,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

    // The consumer side must never pop an empty FIFO.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty && !flush));

endmodule

// File: rtl/vga_pix_fetch.sv
// Streams one frame of words out of a read-latency BRAM into a small FWFT
// buffer feeding the VGA timing logic, using credit-based read issue.
module vga_pix_fetch
    import vga_fetch_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  RAM_DEPTH  = 512,
    parameter int  RD_LAT     = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int AW         = clogb2(RAM_DEPTH - 1)
) (
    input  logic              clkb,
    input  logic              rstb,
    input  logic              frame_start,
    output logic [AW-1:0]     bram_addrb,
    output logic              bram_enb,
    output logic              bram_regceb,
    output logic              bram_rstb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int XW  = clogb2(RAM_DEPTH);
    localparam int CW  = clogb2(FIFO_DEPTH);
    localparam int IFW = clogb2(RD_LAT);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [AW-1:0]     r_rd_addr;
    logic [RD_LAT-1:0] r_pipe;
    logic [XW-1:0]     r_xfer_cnt;
    logic              r_underrun;

    logic [IFW-1:0]    w_in_flight;
    logic [15:0]       w_outstanding;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_last_addr;
    logic              w_busy;
    logic              w_push;
    logic              w_pop;
    logic              w_pix_valid;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_underrun_set;

    // Count reads still travelling through the BRAM pipeline.
    always_comb begin
        w_in_flight = {IFW{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + IFW'(r_pipe[i]);
        end
    end

    // Credit: every outstanding read already owns a FIFO slot, so the FIFO can
    // never overflow. Only registered state feeds this, never pix_ready.
    assign w_outstanding = 16'(w_in_flight) + 16'(w_fifo_count);
    assign w_credit_ok   = (w_outstanding < 16'(FIFO_DEPTH));
    assign w_issue       = (r_state == ST_FETCH) && w_credit_ok;
    assign w_last_addr   = (r_rd_addr == AW'(RAM_DEPTH - 1));
    assign w_busy        = (r_state != ST_IDLE);

    assign w_push        = r_pipe[RD_LAT-1];
    assign w_pix_valid   = !w_fifo_empty;
    assign w_pop         = w_pix_valid && pix_ready;

    // Starvation only counts between the first and the last word of a frame.
    assign w_underrun_set = pix_ready && !w_pix_valid && w_busy
                         && (r_xfer_cnt != {XW{1'b0}})
                         && (r_xfer_cnt != XW'(RAM_DEPTH));

    // Sequencer state register.
    always_ff @(posedge clkb) begin
        if (rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a new frame_start always restarts fetching.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (frame_start) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_issue && w_last_addr) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (frame_start) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_fifo_empty && (r_pipe == {RD_LAT{1'b0}})) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read address walks 0..RAM_DEPTH-1 and parks on the last address.
    always_ff @(posedge clkb) begin
        if (rstb || frame_start) begin
            r_rd_addr <= {AW{1'b0}};
        end else if (w_issue && !w_last_addr) begin
            r_rd_addr <= r_rd_addr + AW'(1'b1);
        end else begin
            r_rd_addr <= r_rd_addr;
        end
    end

    // Read-valid shift register; clearing it discards data still in the BRAM.
    always_ff @(posedge clkb) begin
        if (rstb || frame_start) begin
            r_pipe <= {RD_LAT{1'b0}};
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Words handed to the consumer in the current frame.
    always_ff @(posedge clkb) begin
        if (rstb || frame_start) begin
            r_xfer_cnt <= {XW{1'b0}};
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + XW'(1'b1);
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    // Sticky underrun flag, cleared only by a new frame or reset.
    always_ff @(posedge clkb) begin
        if (rstb || frame_start) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else begin
            r_underrun <= r_underrun;
        end
    end

    fwft_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clkb),
        .rst       (rstb),
        .flush     (frame_start),
        .push      (w_push),
        .push_data (bram_doutb),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign bram_addrb  = r_rd_addr;
    assign bram_enb    = w_issue && !rstb;
    assign bram_regceb = 1'b1;
    assign bram_rstb   = rstb;
    assign pix_data    = w_fifo_head;
    assign pix_valid   = w_pix_valid;
    assign busy        = w_busy;
    assign frame_done  = w_pop && !frame_start && !rstb
                      && (r_xfer_cnt == XW'(RAM_DEPTH - 1));
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_vga_pix_fetch.sv
// Scoreboard bench for vga_pix_fetch with a latency BRAM model.
module tb_vga_pix_fetch;

    localparam int DATA_W     = 32;
    localparam int RAM_DEPTH  = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 3;

    logic              clkb = 1'b0;
    logic              rstb;
    logic              frame_start;
    logic [AW-1:0]     bram_addrb;
    logic              bram_enb;
    logic              bram_regceb;
    logic              bram_rstb;
    logic [DATA_W-1:0] bram_doutb;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              busy;
    logic              frame_done;
    logic              underrun;

    always #5 clkb = ~clkb;

    vga_pix_fetch #(
        .DATA_W     (DATA_W),
        .RAM_DEPTH  (RAM_DEPTH),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clkb        (clkb),
        .rstb        (rstb),
        .frame_start (frame_start),
        .bram_addrb  (bram_addrb),
        .bram_enb    (bram_enb),
        .bram_regceb (bram_regceb),
        .bram_rstb   (bram_rstb),
        .bram_doutb  (bram_doutb),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    // BRAM model: data for an enabled read appears RD_LAT cycles later; garbage otherwise.
    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clkb) begin
        rd_pipe[0] <= bram_enb ? mem[bram_addrb] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_doutb = rd_pipe[RD_LAT-1];

    typedef struct {
        int                fid;
        int                idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   drv_fid  = 0;
    int   checks   = 0;
    int   errors   = 0;

    int   mon_fid     = 0;
    bit   mon_active  = 1'b0;
    int   iss_cnt     = 0;
    int   xfer_cnt    = 0;
    int   exp_addr    = 0;
    int   done_cnt    = 0;
    bit   ur_check_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    // Issue frame_start and queue the words the frame must deliver.
    task automatic start_frame();
        drv_fid++;
        for (int i = 0; i < RAM_DEPTH; i++) exp_q.push_back('{fid: drv_fid, idx: i, data: mem[i]});
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // mode 0: ready held high, 1: toggling, 2: random.
    task automatic run_until_done(input int mode, input int budget);
        int start;
        int c;
        start = done_cnt;
        c = 0;
        while (done_cnt == start && c < budget) begin
            case (mode)
                1:       pix_ready = ~pix_ready;
                2:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = 1'b1;
            endcase
            tick();
            c++;
        end
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", budget);
        end
    endtask

    task automatic wait_xfer(input int k, input int budget);
        int c;
        c = 0;
        while (xfer_cnt < k && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (xfer_cnt < k) begin
            errors++;
            $display("FAIL xfer_wait: got %0d words expected %0d", xfer_cnt, k);
        end
    endtask

    // Monitor: compares every transfer, read address and frame_done against the scoreboard.
    always @(negedge clkb) begin
        exp_t e;
        logic fd_exp;
        fd_exp = 1'b0;
        chk("regceb", 64'(bram_regceb), 64'(1'b1));
        chk("bram_rstb", 64'(bram_rstb), 64'(rstb));
        if (rstb) chk("enb_in_reset", 64'(bram_enb), 64'(1'b0));
        if (bram_enb) begin
            chk("rd_addr", 64'(bram_addrb), 64'(exp_addr));
            chk("credit", 64'((iss_cnt - xfer_cnt) < FIFO_DEPTH), 64'(1'b1));
            exp_addr++;
            iss_cnt++;
        end
        if (pix_valid && pix_ready) begin
            while (exp_q.size() > 0 && exp_q[0].fid != mon_fid) void'(exp_q.pop_front());
            if (!mon_active || exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %0h expected no transfer at %0t", pix_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pix_data", 64'(pix_data), 64'(e.data));
                fd_exp = (e.idx == RAM_DEPTH - 1) && !frame_start;
            end
            xfer_cnt++;
        end
        chk("frame_done", 64'(frame_done), 64'(fd_exp));
        if (frame_done) done_cnt++;
        if (ur_check_en) chk("underrun_quiet", 64'(underrun), 64'(1'b0));
        if (rstb) begin
            mon_active = 1'b0;
            iss_cnt    = 0;
            xfer_cnt   = 0;
            exp_addr   = 0;
        end else if (frame_start) begin
            mon_active = 1'b1;
            mon_fid    = drv_fid;
            iss_cnt    = 0;
            xfer_cnt   = 0;
            exp_addr   = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int start;
        int c;
        rstb        = 1'b1;
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = DATA_W'(i);

        // Reset values while reset is held.
        repeat (3) tick();
        chk("rst_enb", 64'(bram_enb), 64'(1'b0));
        chk("rst_addr", 64'(bram_addrb), 64'(0));
        chk("rst_valid", 64'(pix_valid), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(frame_done), 64'(1'b0));
        chk("rst_underrun", 64'(underrun), 64'(1'b0));
        rstb = 1'b0;
        tick();

        // Straight frame with the consumer always ready.
        pix_ready = 1'b1;
        start_frame();
        @(negedge clkb);
        chk("first_enb", 64'(bram_enb), 64'(1'b1));
        chk("first_addr", 64'(bram_addrb), 64'(0));
        chk("busy_fetch", 64'(busy), 64'(1'b1));
        run_until_done(0, 100);
        repeat (3) tick();
        chk("busy_after", 64'(busy), 64'(1'b0));
        chk("valid_after", 64'(pix_valid), 64'(1'b0));

        // Consumer stalled: only FIFO_DEPTH reads may be issued.
        pix_ready = 1'b0;
        start_frame();
        repeat (12) tick();
        chk("stall_enb_count", 64'(iss_cnt), 64'(FIFO_DEPTH));
        chk("stall_valid", 64'(pix_valid), 64'(1'b1));
        chk("stall_fifo_count", 64'(dut.w_fifo_count), 64'(FIFO_DEPTH));
        run_until_done(0, 100);

        // Toggling ready.
        pix_ready = 1'b0;
        start_frame();
        run_until_done(1, 100);
        repeat (3) tick();

        // Abort around word 3: the restarted frame must begin with word 0.
        pix_ready = 1'b1;
        start_frame();
        wait_xfer(3, 50);
        start_frame();
        run_until_done(0, 100);
        repeat (3) tick();

        // Starve the consumer by blocking new reads after word 2.
        ur_check_en = 1'b0;
        pix_ready   = 1'b1;
        start_frame();
        wait_xfer(2, 50);
        force dut.w_credit_ok = 1'b0;
        repeat (10) tick();
        chk("starved_valid", 64'(pix_valid), 64'(1'b0));
        chk("underrun_set", 64'(underrun), 64'(1'b1));
        release dut.w_credit_ok;
        run_until_done(0, 100);
        repeat (3) tick();
        chk("underrun_sticky", 64'(underrun), 64'(1'b1));
        start_frame();
        chk("underrun_clear", 64'(underrun), 64'(1'b0));
        ur_check_en = 1'b1;
        run_until_done(0, 100);
        repeat (3) tick();

        // Reset with two reads in flight.
        pix_ready = 1'b1;
        start_frame();
        tick();
        tick();
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        chk("rst_mid_valid", 64'(pix_valid), 64'(1'b0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_no_push", 64'(pix_valid), 64'(1'b0));
        end
        chk("rst_mid_busy", 64'(busy), 64'(1'b0));
        start_frame();
        run_until_done(0, 100);
        repeat (3) tick();

        // Random data, random ready and occasional aborts.
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] = $urandom();
            pix_ready = 1'($urandom_range(0, 1));
            start = done_cnt;
            start_frame();
            c = 0;
            while (done_cnt == start && c < 600) begin
                pix_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) start_frame();
                else tick();
                c++;
            end
            checks++;
            if (done_cnt == start) begin
                errors++;
                $display("FAIL rand_timeout: got no frame_done expected one in frame %0d", f);
            end
            repeat (4) tick();
            chk("rand_busy_idle", 64'(busy), 64'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
